// File: rtl/multiplier_slice_pipe.sv
// Tiled unsigned multiplier: partial products, row sums and final sum, each in its own register stage.
// Latency 3 cycles from accept to out_valid, one beat per cycle.
// A stalled output (out_valid && !out_ready) freezes every stage and drops in_ready.
module multiplier_slice_pipe #(
  parameter int MUL_SIZE = 56,
  parameter int RADIX    = 54,
  parameter int TILE     = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_SIZE-1:0] a,
  input  logic [MUL_SIZE-1:0] b,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RADIX-1:0]    res,
  output logic                busy
);

  localparam int NT = MUL_SIZE / TILE;
  localparam int NP = NT * NT;
  localparam int PW = 2 * MUL_SIZE;
  localparam int LW = MUL_SIZE - (NT - 1) * TILE;
  localparam logic [PW-1:0] TMASK = (PW'(1) << TILE) - PW'(1);
  localparam logic [PW-1:0] LMASK = (PW'(1) << LW) - PW'(1);

  // The mode 01 field and the mode 10 field must both fit inside the product.
  if (2 * RADIX + 2 > PW) begin : g_bad_radix
    $error("multiplier_slice_pipe: RADIX too large for MUL_SIZE");
  end

  logic          en;
  logic [PW-1:0] a_t    [NT];
  logic [PW-1:0] b_t    [NT];
  logic [PW-1:0] prod_d [NP];
  logic [PW-1:0] prod_q [NP];
  logic [PW-1:0] row_d  [NT];
  logic [PW-1:0] row_q  [NT];
  logic [PW-1:0] sum_d;
  logic [PW-1:0] p_q;
  logic          v1, v2, v3;
  logic [1:0]    mode1, mode2, mode3;
  logic          unused_p_bits;

  // The whole pipe moves together unless the result sits unaccepted at the output.
  assign en        = !(v3 && !out_ready);
  assign in_ready  = en;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  // Not every product bit feeds a result field for every parameter set.
  assign unused_p_bits = ^p_q;

  // Split operands into tiles (the last tile takes the leftover high bits) and form the shifted tile products.
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      a_t[i] = (PW'(a) >> (i * TILE)) & ((i == NT - 1) ? LMASK : TMASK);
      b_t[i] = (PW'(b) >> (i * TILE)) & ((i == NT - 1) ? LMASK : TMASK);
    end
    for (int i = 0; i < NT; i++) begin
      for (int j = 0; j < NT; j++) begin
        prod_d[i*NT+j] = (a_t[i] * b_t[j]) << ((i + j) * TILE);
      end
    end
  end

  // Row i collects every product that uses tile i of a.
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      row_d[i] = '0;
      for (int j = 0; j < NT; j++) begin
        row_d[i] = row_d[i] + prod_q[i*NT+j];
      end
    end
  end

  // Final sum of all rows gives the exact full-width product.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NT; i++) begin
      sum_d = sum_d + row_q[i];
    end
  end

  // Stage 1: tile products; data only loads for a real beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      mode1 <= 2'b00;
      for (int k = 0; k < NP; k++) prod_q[k] <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        mode1 <= mode;
        for (int k = 0; k < NP; k++) prod_q[k] <= prod_d[k];
      end
    end
  end

  // Stage 2: row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      mode2 <= 2'b00;
      for (int k = 0; k < NT; k++) row_q[k] <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        mode2 <= mode1;
        for (int k = 0; k < NT; k++) row_q[k] <= row_d[k];
      end
    end
  end

  // Stage 3: full product; holds across bubbles so res never moves while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      mode3 <= 2'b00;
      p_q   <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        mode3 <= mode2;
        p_q   <= sum_d;
      end
    end
  end

  // Field select from the stage-3 register only.
  always_comb begin
    res = '0;
    case (mode3)
      2'b00:   res = p_q[RADIX-1:0];
      2'b01:   res = p_q[2*RADIX-1 -: RADIX];
      2'b10:   res = RADIX'(p_q[PW-1 -: 2]);
      default: res = '0;
    endcase
  end

endmodule

// File: doc/multiplier_slice_pipe.md
MULTIPLIER_SLICE_PIPE -- requirements
Module: multiplier_slice_pipe

Interface
REQ-001 Parameter MUL_SIZE, default 56, operand width in bits.
REQ-002 Parameter RADIX, default 54, result field width; legal only if 2*RADIX+2 <= 2*MUL_SIZE.
REQ-003 Parameter TILE, default 18, DSP tile width; NT = MUL_SIZE/TILE (floor) tiles per operand.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  MUL_SIZE  unsigned multiplicand.
REQ-009 b  input  MUL_SIZE  unsigned multiplier.
REQ-010 mode  input  2  field select: 00 low, 01 middle, 10 upper-2, 11 reserved.
REQ-011 out_valid  output  1  res holds a completed result.
REQ-012 out_ready  input  1  downstream accepts res.
REQ-013 res  output  RADIX  selected product field.
REQ-014 busy  output  1  high while any pipeline stage holds a valid beat.

Function
REQ-015 Operands SHALL be split into NT tiles: tiles 0..NT-2 TILE bits wide, tile NT-1 holding the remaining MUL_SIZE-(NT-1)*TILE bits (default 18/18/20).
REQ-016 Stage 1 SHALL register all NT*NT tile products, each shifted left by (i+j)*TILE, in 2*MUL_SIZE-bit registers.
REQ-017 Stage 2 SHALL register NT row sums, row i = sum over j of product(i,j).
REQ-018 Stage 3 SHALL register the sum of the row sums, i.e. the exact 2*MUL_SIZE-bit product a*b, no truncation.
REQ-019 Latency SHALL be exactly 3 cycles from accepted beat (in_valid && in_ready) to out_valid with no backpressure; throughput one beat per cycle.
REQ-020 mode SHALL be captured with the operands and carried with its beat through all stages; later mode changes do not affect in-flight beats.
REQ-021 res for mode 00 SHALL be P[RADIX-1:0]; mode 01 P[2*RADIX-1:RADIX]; mode 10 P[2*MUL_SIZE-1:2*MUL_SIZE-2] zero-extended to RADIX; mode 11 all zeros with out_valid still asserted.
REQ-022 Each stage SHALL carry a valid bit; res SHALL be driven from the stage-3 register only.
REQ-023 Pipeline advance enable SHALL be en = !(out_valid && !out_ready); when en is low all stage registers and valid bits hold.
REQ-024 in_ready SHALL equal en; a beat presented while in_ready is low is not accepted and must be held by the source.
REQ-025 res and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-026 Bubbles (in_valid low while en high) SHALL propagate as invalid stages; stage data of an invalid beat is don't-care but res SHALL NOT change while out_valid is low.
REQ-027 Simultaneous accept at input and drain at output in one cycle SHALL lose no beat and duplicate no beat.
REQ-028 busy SHALL be the OR of the three stage valid bits.

Reset
REQ-029 On rst_n low, asynchronously: all valid bits 0, out_valid 0, busy 0, res 0, all stage registers 0.
REQ-030 in_ready SHALL read 1 during and after reset (out_valid is 0).
REQ-031 Reset mid-operation SHALL discard all in-flight beats; first beat accepted after release appears 3 cycles later.

Verification
REQ-032 a=3, b=5, mode=00, out_ready=1 -> out_valid high exactly 3 cycles after accept, res=15.
REQ-033 a=b=2^56-1, mode=00/01/10 on consecutive cycles -> res 1, then 0x3FFFFFFFFFFFF8, then 3, on three consecutive cycles.
REQ-034 a=b=2^55, mode=01 then mode=10 -> res 0, then 1.
REQ-035 Stream 6 random beats, out_ready low for cycles 4-7 -> in_ready low same cycles, res frozen, all 6 results delivered in order against a*b reference model.
REQ-036 Assert rst_n low with 3 beats in flight -> out_valid and busy 0 immediately; no stale result after release.
REQ-037 Re-run REQ-032/033 with MUL_SIZE=40, RADIX=38, TILE=18 (tiles 18/22) -> results match reference model.
